// File: rtl/arb_pkg.sv
// Shared constants and helpers for the weighted round-robin packet arbiter.
package arb_pkg;

  // Ceiling log2 for sizing channel indices (valid for v >= 2).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // FSM state encodings.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // A programmed weight of zero is loaded as this packet quota.
  localparam int unsigned WGT_ZERO_SUB = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: first requester at or after ptr.
module rr_pick
  import arb_pkg::*;
#(
  parameter int CHN_NUM = 8,
  parameter int IDX_W   = 3
) (
  input  logic [CHN_NUM-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [CHN_NUM-1:0] win,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);

  logic        found;
  int unsigned cand;

  // Walk ptr, ptr+1, ... with wrap at CHN_NUM; the first hit wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    win     = '0;
    for (int unsigned i = 0; i < CHN_NUM; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= 32'(CHN_NUM)) cand = cand - 32'(CHN_NUM);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
    if (found) win[win_idx] = 1'b1;
    any = found;
  end

endmodule

// File: rtl/wrr_pkt_arbiter.sv
// Packet-locked weighted round-robin arbiter: grant held until eop, up to
// weight[i] back-to-back packets per ownership, then the pointer rotates.
module wrr_pkt_arbiter
  import arb_pkg::*;
#(
  parameter  int CHN_NUM = 8,
  parameter  int WGT_W   = 4,
  localparam int IDX_W   = clog2(CHN_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHN_NUM-1:0]       req,
  input  logic [CHN_NUM*WGT_W-1:0] weight,
  input  logic                     ack,
  input  logic                     eop,
  output logic [CHN_NUM-1:0]       grant,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     grant_vld
);

  logic [0:0]         state;
  logic [IDX_W-1:0]   ptr;
  logic [WGT_W-1:0]   credit;
  logic [WGT_W-1:0]   credit_dec;
  logic [WGT_W-1:0]   win_wgt;
  logic [WGT_W-1:0]   load_wgt;
  logic [CHN_NUM-1:0] win;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic               any;
  logic               pkt_end;
  logic               keep;

  rr_pick #(
    .CHN_NUM(CHN_NUM),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .win    (win),
    .win_idx(win_idx),
    .any    (any)
  );

  // Quota of the candidate winner, next pointer, and packet-end decision.
  always_comb begin
    win_wgt    = weight[32'(win_idx)*WGT_W +: WGT_W];
    load_wgt   = (win_wgt == '0) ? WGT_W'(WGT_ZERO_SUB) : win_wgt;
    pkt_end    = grant_vld & ack & eop;
    credit_dec = credit - 1'b1;
    keep       = (credit_dec != '0) && req[grant_idx];
    next_ptr   = (32'(grant_idx) == 32'(CHN_NUM - 1)) ? '0 : grant_idx + 1'b1;
  end

  // FSM, credit counter, rotation pointer and registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      credit    <= '0;
      grant     <= '0;
      grant_idx <= '0;
      grant_vld <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (any) begin
        grant     <= win;
        grant_idx <= win_idx;
        grant_vld <= 1'b1;
        credit    <= load_wgt;
        state     <= ST_GRANT;
      end
    end else begin
      // Credit is at least 1 in GRANT, so the decrement never wraps.
      if (pkt_end) begin
        credit <= credit_dec;
        if (!keep) begin
          grant     <= '0;
          grant_vld <= 1'b0;
          ptr       <= next_ptr;
          state     <= ST_IDLE;
        end
      end
    end
  end

endmodule
